fetch_decode_stage: RTL and testbench
=====================================

// Module: fetch_decode_stage
// PURPOSE
//  Instruction fetch + field-decode stage of the 16-bit processor. Keeps the PC, reads
//  instruction words from instruction memory with a req/ack handshake, latches them in
//  an IR and presents decoded fields. imm8 feeds the 8-to-16 sign-extension stage
//  directly downstream; opcode/register fields go to the register file and control.
// PARAMETERS
//  PC_W      8      PC / imem address width (word addressed)
//  RESET_PC  0      PC value loaded on reset
//  HALT_OP   4'hF   opcode that stops fetching
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     asynchronous, active-low reset (0 = reset)
//  imem_rd       out  1     read request, held high until imem_ack
//  imem_addr     out  PC_W  read address (= pc while imem_rd)
//  imem_data     in   16    instruction word, valid when imem_ack=1
//  imem_ack      in   1     one-cycle data-valid strobe from memory
//  stall         in   1     downstream not ready; hold current instruction
//  branch_taken  in   1     redirect fetch (one-cycle pulse)
//  branch_target in   PC_W  new PC when branch_taken
//  valid         out  1     decoded fields below are a live instruction
//  pc_out        out  PC_W  address the presented instruction came from
//  opcode        out  4     IR[15:12]
//  rd            out  4     IR[11:8]
//  rs            out  4     IR[7:4]
//  rt            out  4     IR[3:0]
//  imm8          out  8     IR[7:0], raw, to sign-extension stage
//  halted        out  1     HALT state reached
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, pc=RESET_PC, IR=0, squash=0; all outputs 0.
//  FSM states: IDLE, REQ, HOLD, HALT.
//   IDLE: one cycle after rst rises -> REQ.
//   REQ : imem_rd=1, imem_addr=pc. On imem_ack (and squash=0): IR<=imem_data,
//         pc_out<=pc, pc<=pc+1 (mod 2^PC_W, 2^PC_W-1 wraps to 0) -> HOLD.
//         Fetch latency >= 1 cycle from request; ack in first REQ cycle allowed.
//   HOLD: valid=1, fields = IR. stall=1 -> stay, outputs frozen. stall=0 -> instruction
//         consumed this cycle; if opcode==HALT_OP -> HALT, else -> REQ (valid=0 next).
//   HALT: imem_rd=0, valid=0, halted=1; leave only via reset. branch_taken ignored.
//  Branch (IDLE/REQ/HOLD): pc<=branch_target; valid drops next cycle; state -> REQ.
//   In REQ with request outstanding: set squash; the next imem_ack is discarded
//   (squash cleared), then request re-issued at new pc. Branch+ack same cycle:
//   ack data discarded, no squash needed. Branch beats stall in HOLD.
//  imem_rd never deasserts before ack except on branch redirect into squash wait;
//   during squash wait imem_rd=0. Decoded outputs are registered (no comb path
//   from imem_data to outputs). Reset mid-fetch: request dropped, late ack ignored.
// STRUCTURE
//  Shared include proc_defs.vh: opcode constants (incl. HALT_OP), IR field bit
//  positions, FSM state encodings (2-bit), PC_W default.
//  Sub-module pc_reg: PC register with load (branch_target), increment-with-wrap,
//  async active-low reset to RESET_PC. FSM, squash flag and IR in this module.
// TESTING
//  1 Reset then ack after 2 cycles, imem_data=16'h3A80 -> valid=1, opcode=3, rd=A,
//    imm8=8'h80, pc_out=0; next request addr=1.
//  2 HOLD with stall=1 for 3 cycles -> outputs unchanged, imem_rd=0; stall=0 -> REQ addr+1.
//  3 branch_taken, target=8'h40 while REQ outstanding -> next ack discarded, new
//    imem_addr=8'h40, presented pc_out=8'h40.
//  4 branch_taken with stall=1 in HOLD -> valid=0 next cycle, fetch from target.
//  5 PC=8'hFF fetch -> next imem_addr=8'h00.
//  6 imem_data=16'hF000 consumed -> halted=1, imem_rd stays 0, branch ignored;
//    rst=0 mid-fetch -> all outputs 0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode stage: opcode constants, IR field
// positions, fetch FSM state encoding and the IR field decoder.
package fetch_decode_stage_pkg;

  localparam int PC_W_DEF = 8;

  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [7:0] imm8;
  } ir_fields_t;

  // imm8 overlaps rs/rt; the instruction format decides which one is meaningful.
  function automatic ir_fields_t decode_ir(input logic [15:0] ir);
    ir_fields_t f;
    f.opcode = ir[OPC_MSB:OPC_LSB];
    f.rd     = ir[RD_MSB:RD_LSB];
    f.rs     = ir[RS_MSB:RS_LSB];
    f.rt     = ir[RT_MSB:RT_LSB];
    f.imm8   = ir[IMM_MSB:IMM_LSB];
    return f;
  endfunction

endpackage

// File: rtl/fetch_decode_stage_pc_reg.sv
// Program counter: branch load has priority over increment; increment wraps
// modulo 2^PC_W.
module fetch_decode_stage_pc_reg #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_val,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch + field decode: PC, imem req/ack handshake with branch
// squash, instruction register and registered decoded fields.
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = OP_HALT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            valid,
  output logic [PC_W-1:0] pc_out,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs,
  output logic [3:0]      rt,
  output logic [7:0]      imm8,
  output logic            halted
);

  fetch_state_e    r_state;
  logic            r_squash;
  logic            r_imem_rd;
  logic            r_valid;
  logic            r_halted;
  logic [15:0]     r_ir;
  logic [PC_W-1:0] r_pc_out;

  logic [PC_W-1:0] w_pc;
  logic            w_pc_load;
  logic            w_accept;
  ir_fields_t      w_fields;

  // A redirect is honoured everywhere except HALT; it always wins over a
  // same-cycle ack, so the ack data is dropped rather than latched.
  assign w_pc_load = branch_taken && (r_state != ST_HALT);
  assign w_accept  = (r_state == ST_REQ) && r_imem_rd && imem_ack && !branch_taken;

  fetch_decode_stage_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_pc_load),
    .i_load_val (branch_target),
    .i_inc      (w_accept),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_squash  <= 1'b0;
      r_imem_rd <= 1'b0;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
      r_ir      <= '0;
      r_pc_out  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state   <= ST_REQ;
          r_imem_rd <= 1'b1;
        end

        ST_REQ: begin
          if (branch_taken) begin
            // Without a same-cycle ack the outstanding read still has to
            // return; wait for it with the request dropped, then discard it.
            r_squash  <= !imem_ack;
            r_imem_rd <= imem_ack;
          end else if (imem_ack && r_squash) begin
            r_squash  <= 1'b0;
            r_imem_rd <= 1'b1;
          end else if (w_accept) begin
            r_ir      <= imem_data;
            r_pc_out  <= w_pc;
            r_valid   <= 1'b1;
            r_imem_rd <= 1'b0;
            r_state   <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (branch_taken) begin
            r_valid   <= 1'b0;
            r_imem_rd <= 1'b1;
            r_state   <= ST_REQ;
          end else if (!stall) begin
            r_valid <= 1'b0;
            if (w_fields.opcode == HALT_OP) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end else begin
              r_imem_rd <= 1'b1;
              r_state   <= ST_REQ;
            end
          end
        end

        ST_HALT: begin
          r_state <= ST_HALT;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_fields = decode_ir(r_ir);

  assign imem_rd   = r_imem_rd;
  assign imem_addr = r_imem_rd ? w_pc : '0;
  assign valid     = r_valid;
  assign pc_out    = r_pc_out;
  assign opcode    = w_fields.opcode;
  assign rd        = w_fields.rd;
  assign rs        = w_fields.rs;
  assign rt        = w_fields.rt;
  assign imm8      = w_fields.imm8;
  assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: a randomized imem responder, a
// program-order reference model feeding an expectation queue, and a monitor.
module tb_fetch_decode_stage;

  localparam int         PC_W     = 8;
  localparam logic [7:0] RESET_PC = 8'h00;
  localparam logic [3:0] HALT_OPC = 4'hF;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic            imem_ack;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            valid;
  logic [PC_W-1:0] pc_out;
  logic [3:0]      opcode, rd, rs, rt;
  logic [7:0]      imm8;
  logic            halted;

  fetch_decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_rd       (imem_rd),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_ack      (imem_ack),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .valid         (valid),
    .pc_out        (pc_out),
    .opcode        (opcode),
    .rd            (rd),
    .rs            (rs),
    .rt            (rt),
    .imm8          (imm8),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [15:0]     instr;
  } pres_t;

  pres_t           exp_q[$];
  logic [15:0]     mem [256];
  int              n_cmp = 0;
  int              n_fail = 0;
  int              n_pres = 0;
  logic [PC_W-1:0] model_pc;
  bit              model_halted;
  int              force_lat = -1;
  int              rst_epoch = 0;

  // responder state
  bit              busy = 1'b0;
  bit              squash_wait;
  int              lat_left;
  int              req_epoch;
  logic [PC_W-1:0] req_addr;

  // monitor state
  bit              prev_valid = 1'b0;
  pres_t           held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},  valid, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_rd_req"}, imem_rd, 0);
    check({tag, "_addr"},   imem_addr, 0);
    check({tag, "_pc_out"}, pc_out, 0);
    check({tag, "_fields"}, {opcode, rd, rs, rt, imm8}, 0);
  endtask

  // Reference model: the next instruction the stage must present is simply
  // the word at the architectural PC, which follows program order.
  task automatic model_expect(input logic [PC_W-1:0] pc);
    pres_t p;
    p.pc     = pc;
    p.instr  = mem[pc];
    model_pc = pc;
    exp_q.push_back(p);
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_halted = 1'b0;
    model_expect(RESET_PC);
  endtask

  task automatic drive_cycle(input bit s, input bit br, input logic [PC_W-1:0] tgt);
    @(posedge clk);
    #2;
    stall         = s;
    branch_taken  = br;
    branch_target = br ? tgt : '0;
    if (rst && !model_halted) begin
      if (br) begin
        exp_q.delete();
        model_expect(tgt);
      end else if (valid && !s) begin
        if (mem[model_pc][15:12] == HALT_OPC) model_halted = 1'b1;
        else model_expect(model_pc + PC_W'(1));
      end
    end
  endtask

  // Instruction memory: random latency 0..3 cycles after the request is seen.
  initial begin
    imem_ack  = 1'b0;
    imem_data = '0;
    forever begin
      @(posedge clk);
      #3;
      imem_ack = 1'b0;
      if (busy && req_epoch != rst_epoch) busy = 1'b0;
      if (busy) begin
        check("imem_rd_while_pending", imem_rd, !squash_wait);
        squash_wait = squash_wait | branch_taken;
        lat_left--;
      end else if (rst && imem_rd) begin
        busy        = 1'b1;
        req_addr    = imem_addr;
        req_epoch   = rst_epoch;
        squash_wait = branch_taken;
        lat_left    = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        force_lat   = -1;
      end
      if (busy && lat_left == 0) begin
        imem_ack  = 1'b1;
        imem_data = mem[req_addr];
        busy      = 1'b0;
      end
    end
  end

  // Monitor: each new presentation pops the scoreboard; held ones must not move.
  initial begin
    pres_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_presentation_pc", pc_out, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pres_pc_out", pc_out, e.pc);
          check("pres_fields", {opcode, rd, rs, rt}, e.instr);
          check("pres_imm8",   imm8, e.instr[7:0]);
          held = e;
          n_pres++;
        end
        check("pres_imem_rd", imem_rd, 0);
      end else if (valid && prev_valid) begin
        check("hold_pc_out", pc_out, held.pc);
        check("hold_fields", {opcode, rd, rs, rt, imm8}, {held.instr, held.instr[7:0]});
        check("hold_imem_rd", imem_rd, 0);
      end
      prev_valid = valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit              prev_br;
    bit              s, b;
    logic [PC_W-1:0] t;

    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    mem[0] = 16'h3A80;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("reset");

    // First fetch with a two-cycle memory, then a three-cycle stall.
    force_lat = 2;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    for (int c = 0; c < 20 && !valid; c++) drive_cycle(1, 0, '0);
    check("t1_valid",  valid, 1);
    check("t1_opcode", opcode, 4'h3);
    check("t1_rd",     rd, 4'hA);
    check("t1_imm8",   imm8, 8'h80);
    check("t1_pc_out", pc_out, 8'h00);
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1, 0, '0);
      check("t2_stall_valid", valid, 1);
      check("t2_stall_rd",    imem_rd, 0);
    end
    drive_cycle(0, 0, '0);
    for (int c = 0; c < 10 && !imem_rd; c++) drive_cycle(0, 0, '0);
    check("t2_next_addr", imem_addr, 8'h01);

    // Redirect while a read is outstanding: the late data must be dropped.
    for (int c = 0; c < 20 && !imem_rd; c++) drive_cycle(0, 0, '0);
    force_lat = 3;
    drive_cycle(0, 1, 8'h40);
    drive_cycle(0, 0, '0);
    for (int c = 0; c < 20 && !imem_rd; c++) drive_cycle(0, 0, '0);
    check("t3_redirect_addr", imem_addr, 8'h40);

    // Redirect beats a stalled instruction.
    for (int c = 0; c < 20 && !valid; c++) drive_cycle(1, 0, '0);
    drive_cycle(1, 1, 8'h20);
    drive_cycle(1, 0, '0);
    check("t4_valid_dropped", valid, 0);

    // PC wrap from 8'hFF.
    drive_cycle(0, 1, 8'hFF);
    for (int c = 0; c < 30; c++) drive_cycle(0, 0, '0);

    // Randomized traffic.
    prev_br = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      s = ($urandom_range(0, 99) < 30);
      b = !prev_br && ($urandom_range(0, 99) < 6);
      t = ($urandom_range(0, 3) == 0) ? 8'hFF : PC_W'($urandom);
      drive_cycle(s, b, t);
      prev_br = b;
    end
    drive_cycle(0, 0, '0);
    check("progress", n_pres > 100, 1);

    // HALT: consumed halt opcode stops fetching for good.
    @(posedge clk);
    #2;
    rst = 1'b0;
    rst_epoch++;
    model_reset();
    stall        = 1'b0;
    branch_taken = 1'b0;
    mem[8'h80]   = 16'hF000;
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive_cycle(0, 1, 8'h80);
    for (int c = 0; c < 40 && !halted; c++) drive_cycle(0, 0, '0);
    check("t6_halted", halted, 1);
    check("t6_valid",  valid, 0);
    check("t6_rd",     imem_rd, 0);
    for (int c = 0; c < 8; c++) begin
      drive_cycle(0, c[0], 8'h10);
      check("t6_halt_sticky", {halted, imem_rd, valid}, 3'b100);
    end

    // Reset in the middle of a fetch.
    @(posedge clk);
    #2;
    rst = 1'b0;
    rst_epoch++;
    model_reset();
    branch_taken = 1'b0;
    mem[8'h80]   = 16'h1234;
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int c = 0; c < 20 && !imem_rd; c++) drive_cycle(0, 0, '0);
    force_lat = 3;
    check("t6_first_addr", imem_addr, RESET_PC);
    @(posedge clk);
    #4;
    rst = 1'b0;
    rst_epoch++;
    model_reset();
    #1;
    check_zero_outputs("midfetch");
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int c = 0; c < 20 && !imem_rd; c++) drive_cycle(0, 0, '0);
    check("t6_restart_addr", imem_addr, RESET_PC);
    for (int c = 0; c < 20 && !valid; c++) drive_cycle(1, 0, '0);
    check("t6_restart_valid",  valid, 1);
    check("t6_restart_pc_out", pc_out, RESET_PC);
    for (int c = 0; c < 20; c++) drive_cycle(0, 0, '0);
    check("queue_depth", exp_q.size() <= 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
